// File: rtl/sync_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_reader
// Purpose  : Read-side drain controller for sync_fifo. Issues FIFO reads only
//            when the 2-entry skid buffer is guaranteed to have room for the
//            word, captures the word returned by the FIFO's registered RAM one
//            cycle later, and re-presents it on a valid/ready stream at up to
//            one word per cycle.
// Ports    : clk        - sole clock, rising edge
//            rst        - asynchronous active-high reset
//            drain_en   - permits new FIFO reads while high
//            fifo_empty - FIFO empty flag
//            fifo_rd_en - FIFO read strobe (combinational)
//            fifo_data  - FIFO read data, valid the cycle after fifo_rd_en
//            m_valid    - output word valid
//            m_ready    - consumer accepts the word
//            m_data     - output word
//            rd_count   - count of accepted output words
// Options  : SYNC_FIFO_READER_STATS_EN - builds the 16-bit wrapping rd_count
//            counter; when undefined rd_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drain_en,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [15:0]      rd_count
);

    logic [1:0]       r_occ;        // words held in head/tail, 0..2
    logic             r_inflight;   // a FIFO word arrives on fifo_data this cycle
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    logic             w_pop;
    logic [1:0]       w_occ_after_pop;
    logic [1:0]       w_occ_next;

    assign w_pop = m_valid & m_ready;

    // A pop implies occ >= 1, so the subtraction never wraps.
    assign w_occ_after_pop = r_occ - {1'b0, w_pop};

    // occ + inflight is bounded by 2, so the sum always fits in two bits.
    assign w_occ_next = w_occ_after_pop + {1'b0, r_inflight};

    // A read issued now lands next cycle as inflight; requiring the next
    // occupancy to be below 2 reserves the slot that word will need.
    assign fifo_rd_en = drain_en & ~fifo_empty & ~rst & (w_occ_next < 2'd2);

    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_occ      <= w_occ_next;
            r_inflight <= fifo_rd_en;

            // Second word advances into head when the first is consumed.
            if (w_pop && (r_occ == 2'd2)) begin
                r_head <= r_tail;
            end

            // The arriving word goes to whichever slot is next in order once
            // this cycle's pop is accounted for. occ == 2 with inflight set is
            // unreachable, so this never collides with the tail-to-head move.
            if (r_inflight) begin
                if (w_occ_after_pop == 2'd0) begin
                    r_head <= fifo_data;
                end else begin
                    r_tail <= fifo_data;
                end
            end
        end
    end

`ifdef SYNC_FIFO_READER_STATS_EN
    logic [15:0] r_rd_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_count <= 16'd0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
`else
    assign rd_count = 16'd0;
`endif

endmodule

`default_nettype wire
